// File: rtl/writeback_unit.sv
// Writeback stage: one holding register per source (ALU, load return), round-robin
// arbitration on contention, load extraction/extension, registered register-file write port.
module writeback_unit #(
   parameter int unsigned BUS_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [4:0]                alu_rd,
   input  logic [BUS_DATA_WIDTH-1:0] alu_result,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [4:0]                mem_rd,
   input  logic [BUS_DATA_WIDTH-1:0] mem_data,
   input  logic [1:0]                mem_size,
   input  logic                      mem_unsigned,
   input  logic [2:0]                mem_offset,
   output logic                      write_en,
   output logic [4:0]                addressC,
   output logic [BUS_DATA_WIDTH-1:0] writeBack,
   output logic                      misaligned_err
);
   localparam int unsigned W = BUS_DATA_WIDTH;

   logic          alu_full_q, alu_full_d;
   logic [4:0]    alu_rd_q, alu_rd_d;
   logic [W-1:0]  alu_data_q, alu_data_d;
   logic          mem_full_q, mem_full_d;
   logic [4:0]    mem_rd_q, mem_rd_d;
   logic [W-1:0]  mem_data_q, mem_data_d;
   logic [1:0]    mem_size_q, mem_size_d;
   logic          mem_uns_q, mem_uns_d;
   logic [2:0]    mem_off_q, mem_off_d;
   logic          last_mem_q, last_mem_d;
   logic          write_en_q, write_en_d;
   logic          err_q, err_d;
   logic [4:0]    addr_q, addr_d;
   logic [W-1:0]  wb_q, wb_d;

   logic          alu_gnt, mem_gnt, contended, mem_misaligned;
   logic [W-1:0]  mem_shifted, mem_ext;

   // Last-grant only matters (and only moves) when both sources compete.
   always_comb begin
      contended = alu_full_q && mem_full_q;
      alu_gnt   = alu_full_q && (!mem_full_q || last_mem_q);
      mem_gnt   = mem_full_q && (!alu_full_q || !last_mem_q);
      alu_ready = !reset && (!alu_full_q || alu_gnt);
      mem_ready = !reset && (!mem_full_q || mem_gnt);
   end

   always_comb begin
      mem_shifted = mem_data_q >> {mem_off_q, 3'b000};
      mem_ext     = mem_data_q;
      unique case (mem_size_q)
         2'd0: mem_ext = mem_uns_q ? {{(W-8){1'b0}}, mem_shifted[7:0]}
                                   : {{(W-8){mem_shifted[7]}}, mem_shifted[7:0]};
         2'd1: mem_ext = mem_uns_q ? {{(W-16){1'b0}}, mem_shifted[15:0]}
                                   : {{(W-16){mem_shifted[15]}}, mem_shifted[15:0]};
         2'd2: mem_ext = mem_uns_q ? {{(W-32){1'b0}}, mem_shifted[31:0]}
                                   : {{(W-32){mem_shifted[31]}}, mem_shifted[31:0]};
         default: mem_ext = mem_data_q;
      endcase
      unique case (mem_size_q)
         2'd0:    mem_misaligned = 1'b0;
         2'd1:    mem_misaligned = mem_off_q[0];
         2'd2:    mem_misaligned = |mem_off_q[1:0];
         default: mem_misaligned = |mem_off_q;
      endcase
   end

   always_comb begin
      alu_full_d = alu_full_q;
      alu_rd_d   = alu_rd_q;
      alu_data_d = alu_data_q;
      mem_full_d = mem_full_q;
      mem_rd_d   = mem_rd_q;
      mem_data_d = mem_data_q;
      mem_size_d = mem_size_q;
      mem_uns_d  = mem_uns_q;
      mem_off_d  = mem_off_q;
      last_mem_d = last_mem_q;
      write_en_d = 1'b0;
      err_d      = 1'b0;
      addr_d     = addr_q;
      wb_d       = wb_q;

      if (alu_gnt) alu_full_d = 1'b0;
      if (alu_valid && alu_ready) begin
         alu_full_d = 1'b1;
         alu_rd_d   = alu_rd;
         alu_data_d = alu_result;
      end
      if (mem_gnt) mem_full_d = 1'b0;
      if (mem_valid && mem_ready) begin
         mem_full_d = 1'b1;
         mem_rd_d   = mem_rd;
         mem_data_d = mem_data;
         mem_size_d = mem_size;
         mem_uns_d  = mem_unsigned;
         mem_off_d  = mem_offset;
      end

      if (alu_gnt) begin
         if (contended) last_mem_d = 1'b0;
         addr_d     = alu_rd_q;
         wb_d       = alu_data_q;
         write_en_d = alu_rd_q != 5'd0;
      end else if (mem_gnt) begin
         if (contended) last_mem_d = 1'b1;
         addr_d     = mem_rd_q;
         wb_d       = mem_ext;
         write_en_d = (mem_rd_q != 5'd0) && !mem_misaligned;
         err_d      = mem_misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_full_q <= 1'b0;
         alu_rd_q   <= '0;
         alu_data_q <= '0;
         mem_full_q <= 1'b0;
         mem_rd_q   <= '0;
         mem_data_q <= '0;
         mem_size_q <= '0;
         mem_uns_q  <= 1'b0;
         mem_off_q  <= '0;
         last_mem_q <= 1'b0;
         write_en_q <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wb_q       <= '0;
      end else begin
         alu_full_q <= alu_full_d;
         alu_rd_q   <= alu_rd_d;
         alu_data_q <= alu_data_d;
         mem_full_q <= mem_full_d;
         mem_rd_q   <= mem_rd_d;
         mem_data_q <= mem_data_d;
         mem_size_q <= mem_size_d;
         mem_uns_q  <= mem_uns_d;
         mem_off_q  <= mem_off_d;
         last_mem_q <= last_mem_d;
         write_en_q <= write_en_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         wb_q       <= wb_d;
      end
   end

   assign write_en       = write_en_q;
   assign misaligned_err = err_q;
   assign addressC       = addr_q;
   assign writeBack      = wb_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [4:0]  alu_rd, mem_rd, addressC;
   logic [63:0] alu_result, mem_data, writeBack;
   logic [1:0]  mem_size;
   logic        mem_unsigned, write_en, misaligned_err;
   logic [2:0]  mem_offset;

   always #5 clk = ~clk;

   writeback_unit #(.BUS_DATA_WIDTH(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd         (alu_rd),
      .alu_result     (alu_result),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_rd         (mem_rd),
      .mem_data       (mem_data),
      .mem_size       (mem_size),
      .mem_unsigned   (mem_unsigned),
      .mem_offset     (mem_offset),
      .write_en       (write_en),
      .addressC       (addressC),
      .writeBack      (writeBack),
      .misaligned_err (misaligned_err)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic [1:0]  size;
      logic        uns;
      logic [2:0]  off;
   } beat_t;

   beat_t       alu_hq[$];
   beat_t       mem_hq[$];
   bit          last_mem;
   logic        exp_we, exp_err;
   logic [4:0]  exp_addr;
   logic [63:0] exp_wb;
   bit          wb_known;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] extract(input logic [63:0] data, input logic [1:0] size,
                                           input logic uns, input logic [2:0] off);
      int          nbytes;
      logic [63:0] v, mask;
      nbytes = 1 << size;
      v = data >> (8 * off);
      if (nbytes < 8) begin
         mask = (64'd1 << (8 * nbytes)) - 64'd1;
         v    = v & mask;
         if (!uns && v[8*nbytes-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // One clock: present inputs, check readies, advance model, check registered outputs.
   task automatic step(input logic rst,
                       input logic av, input logic [4:0] ard, input logic [63:0] ares,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] mdat,
                       input logic [1:0] msz, input logic muns, input logic [2:0] moff);
      bit    a_full, m_full, contended, exp_ar, exp_mr;
      int    win;
      beat_t b;
      reset = rst; alu_valid = av; alu_rd = ard; alu_result = ares;
      mem_valid = mv; mem_rd = mrd; mem_data = mdat; mem_size = msz;
      mem_unsigned = muns; mem_offset = moff;
      #1;
      a_full    = alu_hq.size() != 0;
      m_full    = mem_hq.size() != 0;
      contended = a_full && m_full;
      if (contended) win = last_mem ? 1 : 2;
      else if (a_full) win = 1;
      else if (m_full) win = 2;
      else win = 0;
      exp_ar = !rst && (!a_full || win == 1);
      exp_mr = !rst && (!m_full || win == 2);
      check("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar});
      check("mem_ready", {63'd0, mem_ready}, {63'd0, exp_mr});
      @(posedge clk);
      if (rst) begin
         alu_hq.delete(); mem_hq.delete();
         last_mem = 0; exp_we = 0; exp_err = 0; exp_addr = 0; exp_wb = 0; wb_known = 1;
      end else begin
         exp_we = 0; exp_err = 0;
         if (win == 1) begin
            b = alu_hq.pop_front();
            if (contended) last_mem = 0;
            exp_addr = b.rd; exp_wb = b.data; wb_known = 1; exp_we = b.rd != 0;
         end else if (win == 2) begin
            b = mem_hq.pop_front();
            if (contended) last_mem = 1;
            exp_addr = b.rd;
            if ((int'(b.off) % (1 << b.size)) != 0) begin
               exp_err = 1; wb_known = 0;
            end else begin
               exp_wb = extract(b.data, b.size, b.uns, b.off); wb_known = 1;
               exp_we = b.rd != 0;
            end
         end
         if (av && exp_ar) alu_hq.push_back('{ard, ares, 2'd3, 1'b0, 3'd0});
         if (mv && exp_mr) mem_hq.push_back('{mrd, mdat, msz, muns, moff});
      end
      @(negedge clk);
      check("write_en", {63'd0, write_en}, {63'd0, exp_we});
      check("misaligned_err", {63'd0, misaligned_err}, {63'd0, exp_err});
      check("addressC", {59'd0, addressC}, {59'd0, exp_addr});
      if (wb_known) check("writeBack", writeBack, exp_wb);
   endtask

   task automatic idle(input logic rst);
      step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; alu_valid = 0; mem_valid = 0; alu_rd = 0; alu_result = 0;
      mem_rd = 0; mem_data = 0; mem_size = 0; mem_unsigned = 0; mem_offset = 0;
      last_mem = 0; wb_known = 1;
      @(negedge clk);
      idle(1);
      check("rst_we", {63'd0, write_en}, 64'd0);
      check("rst_wb", writeBack, 64'd0);
      idle(0);

      // Single ALU beat latency.
      step(0, 1, 5'd5, 64'h2A, 0, 0, 0, 0, 0, 0);
      check("alu_lat_we0", {63'd0, write_en}, 64'd0);
      idle(0);
      check("alu_lat_we1", {63'd0, write_en}, 64'd1);
      check("alu_lat_addr", {59'd0, addressC}, 64'd5);
      check("alu_lat_wb", writeBack, 64'h2A);
      idle(0);
      check("alu_lat_we2", {63'd0, write_en}, 64'd0);

      // Contention: mem first, then ALU; repeat contention favours ALU.
      step(0, 1, 5'd3, 64'h33, 1, 5'd7, 64'h77, 2'd3, 0, 0);
      idle(0);
      check("rr1_addr", {59'd0, addressC}, 64'd7);
      idle(0);
      check("rr2_addr", {59'd0, addressC}, 64'd3);
      step(0, 1, 5'd3, 64'h33, 1, 5'd7, 64'h77, 2'd3, 0, 0);
      idle(0);
      check("rr3_addr", {59'd0, addressC}, 64'd3);
      idle(0);
      check("rr4_addr", {59'd0, addressC}, 64'd7);

      // Load extraction.
      step(0, 0, 0, 0, 1, 5'd1, 64'h0000_0000_8000_0000, 2'd0, 0, 3'd3);
      idle(0);
      check("lb", writeBack, 64'hFFFF_FFFF_FFFF_FF80);
      step(0, 0, 0, 0, 1, 5'd2, 64'hBEEF_0000_0000_0000, 2'd1, 1, 3'd6);
      idle(0);
      check("lhu", writeBack, 64'h0000_0000_0000_BEEF);
      step(0, 0, 0, 0, 1, 5'd3, 64'h8765_4321_0000_0000, 2'd2, 0, 3'd4);
      idle(0);
      check("lw", writeBack, 64'hFFFF_FFFF_8765_4321);

      // Misaligned word and ALU rd=0.
      step(0, 0, 0, 0, 1, 5'd4, 64'h1234, 2'd2, 0, 3'd2);
      idle(0);
      check("mis_err", {63'd0, misaligned_err}, 64'd1);
      check("mis_we", {63'd0, write_en}, 64'd0);
      step(0, 1, 5'd0, 64'h55, 0, 0, 0, 0, 0, 0);
      check("mis_err_drop", {63'd0, misaligned_err}, 64'd0);
      idle(0);
      check("rd0_we", {63'd0, write_en}, 64'd0);
      check("rd0_err", {63'd0, misaligned_err}, 64'd0);

      // Back-to-back ALU beats.
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 5'(i + 1), 64'(i * 16 + 9), 0, 0, 0, 0, 0, 0);
         check("b2b_ready", {63'd0, alu_ready}, 64'd1);
         if (i > 0) check("b2b_addr", {59'd0, addressC}, 64'(i));
      end
      idle(0);
      check("b2b_last", {59'd0, addressC}, 64'd8);
      check("b2b_last_we", {63'd0, write_en}, 64'd1);

      // Reset right after both sources accepted.
      step(0, 1, 5'd9, 64'h99, 1, 5'd10, 64'hAA, 2'd3, 0, 0);
      idle(1);
      check("rst_mid_we", {63'd0, write_en}, 64'd0);
      check("rst_mid_addr", {59'd0, addressC}, 64'd0);
      check("rst_mid_wb", writeBack, 64'd0);
      idle(0);
      check("rst_after_we", {63'd0, write_en}, 64'd0);
      idle(0);
      check("rst_after_we2", {63'd0, write_en}, 64'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
              {$urandom, $urandom},
              ($urandom_range(0, 9) < 6), 5'($urandom_range(1, 31)),
              {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      idle(0);
      idle(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, register/data width; only 64 is supported.
REQ-002 One clock; reset is synchronous and active-high; ports clk and reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 alu_valid  in  1  ALU result beat valid.
REQ-006 alu_ready  out  1  unit can accept ALU beat this cycle.
REQ-007 alu_rd  in  5  ALU destination register.
REQ-008 alu_result  in  64  ALU result.
REQ-009 mem_valid  in  1  load-return beat valid.
REQ-010 mem_ready  out  1  unit can accept load beat this cycle.
REQ-011 mem_rd  in  5  load destination register.
REQ-012 mem_data  in  64  aligned doubleword returned by memory.
REQ-013 mem_size  in  2  0=byte, 1=half, 2=word, 3=dword.
REQ-014 mem_unsigned  in  1  1=zero-extend, 0=sign-extend.
REQ-015 mem_offset  in  3  byte offset of load within doubleword.
REQ-016 write_en  out  1  register-file write strobe (registered).
REQ-017 addressC  out  5  register-file write address (registered).
REQ-018 writeBack  out  64  register-file write data (registered).
REQ-019 misaligned_err  out  1  one-cycle pulse, dropped misaligned load.

Function
REQ-020 Beat accepted at rising edge where valid && ready; captured into that source's single-entry holding register (rd, data, size, unsigned, offset).
REQ-021 ready = holding register empty OR holding register granted this cycle (refill in the same edge as drain); combinational on grant only, never on valid.
REQ-022 Arbiter: one grant per cycle among valid holding registers; lone valid source always granted.
REQ-023 Both valid: grant the source not granted last (round-robin); last-grant flag resets to ALU, so mem wins the first contention.
REQ-024 At the granting edge the holding register clears (unless refilled) and write_en/addressC/writeBack register the granted beat; no grant -> write_en=0 next cycle, addressC/writeBack hold.
REQ-025 Latency: beat accepted at edge E, uncontested -> write_en=1 in cycle after edge E+1; contested loser waits exactly one extra cycle.
REQ-026 Sustained throughput: one write per cycle total; each source one beat per cycle when uncontested.
REQ-027 rd==0: beat accepted and granted normally, but write_en stays 0 for that slot.
REQ-028 Load extraction: byte = mem_data[8*off +: 8]; half = [8*off +: 16]; word = [8*off +: 32]; dword = full; extend to 64 per mem_unsigned (ignored for dword).
REQ-029 Misaligned (half with off[0]!=0, word with off[1:0]!=0, dword with off!=0): write_en=0 for that slot, misaligned_err=1 for exactly the cycle write_en would have been 1.
REQ-030 ALU data passes unmodified.

Reset
REQ-031 At a reset edge: both holding registers empty, last-grant=ALU, write_en=0, misaligned_err=0, addressC=0, writeBack=0; in-flight beats discarded, no write occurs in the following cycle.
REQ-032 During reset, alu_ready and mem_ready are 0; beats presented are not accepted.
REQ-033 Reset asserted mid-operation overrides any grant or capture in that cycle.

Verification
REQ-034 ALU alu_rd=5, alu_result=0x2A accepted at edge 1 -> write_en=1, addressC=5, writeBack=0x2A in cycle after edge 2, write_en=0 next cycle.
REQ-035 ALU rd=3 and mem rd=7 both accepted same edge, first contention -> mem write (addressC=7) one cycle, then ALU write (addressC=3) next cycle; repeat contention -> ALU first.
REQ-036 Loads: LB off=3, data 0x0000_0000_8000_0000 -> 0xFFFF_FFFF_FFFF_FF80; LHU off=6, data 0xBEEF_0000_0000_0000 -> 0x0000_0000_0000_BEEF; LW off=4, data 0x8765_4321_0000_0000 -> 0xFFFF_FFFF_8765_4321.
REQ-037 Load size=2, off=2 -> write_en=0, misaligned_err=1 for one cycle; ALU rd=0 beat -> no write_en, no error.
REQ-038 Back-to-back ALU beats every cycle for 8 cycles, mem idle -> alu_ready never drops, 8 consecutive write_en cycles in order.
REQ-039 Reset asserted the cycle after both sources accepted -> no write_en ever for those beats, ready=0 during reset, all outputs 0 after.
